// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC accumulate engine.
// Holds the FSM state encoding and the operand-address width helper.
package mac_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 20;
    localparam int unsigned DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Address width never collapses below one bit, even for DEPTH=1.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mac_if.sv
// Bus between the control FSM / operand memory (master) and the engine (slave).
interface mac_if #(
    parameter int unsigned DATA_W = mac_pkg::DATA_W_DEF,
    parameter int unsigned ACC_W  = mac_pkg::ACC_W_DEF,
    parameter int unsigned ADDR_W = 3
);
    logic                     clear;
    logic                     run;
    logic [ADDR_W-1:0]        addr;
    logic signed [DATA_W-1:0] a_data;
    logic signed [DATA_W-1:0] b_data;
    logic signed [ACC_W-1:0]  acc;
    logic                     valid;
    logic                     done;
    logic                     ovf;

    modport master (
        output clear, run, a_data, b_data,
        input  addr, acc, valid, done, ovf
    );

    modport slave (
        input  clear, run, a_data, b_data,
        output addr, acc, valid, done, ovf
    );
endinterface

// File: rtl/mac_accum_engine_sat_add.sv
// Signed saturating adder: clamps to the ACC_W range and flags the clamp.
module mac_sat_add #(
    parameter int unsigned ACC_W = mac_pkg::ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] raw;

    // Overflow only when both operands share a sign the wrapped result lacks.
    always_comb begin
        raw = a + b;
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
        sum = raw;
        if (ovf) begin
            sum = a[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end
endmodule

// File: rtl/mac_accum_engine.sv
// Dot-product datapath: walks operand addresses, registers signed products and
// accumulates them with saturation, then holds the result in DONE until cleared.
module mac_accum_engine
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic clk,
    input  logic reset_n,
    mac_if.slave bus
);
    localparam int unsigned ADDR_W = addr_width(DEPTH);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t                   state;
    logic [ADDR_W-1:0]        addr;
    logic signed [PROD_W-1:0] prod_r;
    logic                     p_valid;
    logic signed [ACC_W-1:0]  acc;
    logic                     valid;
    logic                     done;
    logic                     ovf;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  prod_ext_c;
    logic signed [ACC_W-1:0]  sat_sum_c;
    logic                     sat_ovf_c;
    logic                     acc_en_c;

    assign prod_c     = PROD_W'(bus.a_data) * PROD_W'(bus.b_data);
    assign prod_ext_c = ACC_W'(prod_r);
    assign acc_en_c   = p_valid && bus.run;

    mac_sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a   (acc),
        .b   (prod_ext_c),
        .sum (sat_sum_c),
        .ovf (sat_ovf_c)
    );

    // Clear beats run; a low run freezes every register so a stalled run resumes intact.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr    <= '0;
            prod_r  <= '0;
            p_valid <= 1'b0;
            acc     <= '0;
            valid   <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else if (bus.clear) begin
            state   <= IDLE;
            addr    <= '0;
            prod_r  <= '0;
            p_valid <= 1'b0;
            acc     <= '0;
            valid   <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (acc_en_c) begin
                acc   <= sat_sum_c;
                ovf   <= ovf | sat_ovf_c;
                valid <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (bus.run) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.run) begin
                        prod_r  <= prod_c;
                        p_valid <= 1'b1;
                        if (addr == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (bus.run) begin
                        p_valid <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.addr  = addr;
    assign bus.acc   = acc;
    assign bus.valid = valid;
    assign bus.done  = done;
    assign bus.ovf   = ovf;

endmodule
